ps2_key_ctrl: RTL and testbench
===============================

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO depth; power of two, 2..64.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port rx_valid  input  1  one-cycle strobe: PS/2 receiver has a new parity-checked scan byte.
REQ-005 SHALL have port rx_data  input  8  scan byte, qualified by rx_valid.
REQ-006 SHALL have port ev_valid  output  1  FIFO non-empty.
REQ-007 SHALL have port ev_ready  input  1  consumer accepts head event when high with ev_valid.
REQ-008 SHALL have port ev_data  output  10  head event {brk, ext, code[7:0]}.
REQ-009 SHALL have port fifo_cnt  output  log2(DEPTH)+1  occupancy.
REQ-010 SHALL have port key_down  output  1  a key is held (last make not yet broken).
REQ-011 SHALL have port push_cnt  output  8  count of make events pushed.
REQ-012 SHALL have port ovf  output  1  sticky: an event was dropped on a full FIFO.
REQ-013 SHALL have port clr_ovf  input  1  clears ovf.
REQ-014 SHALL have port err  output  1  one-cycle pulse on an error byte.
REQ-015 SHALL have port state  output  2  decoder state code.

Function
REQ-016 Decoder FSM SHALL have states IDLE=0, EXT=1, BRK=2, EXT_BRK=3 and SHALL advance only on cycles with rx_valid=1.
REQ-017 From IDLE: E0 -> EXT; F0 -> BRK; any other byte -> emit {0,0,byte}, stay IDLE.
REQ-018 From EXT: E0 -> EXT; F0 -> EXT_BRK; other -> emit {0,1,byte}, go IDLE.
REQ-019 From BRK: F0 -> BRK; E0 -> EXT_BRK; other -> emit {1,0,byte}, go IDLE.
REQ-020 From EXT_BRK: E0/F0 -> stay; other -> emit {1,1,byte}, go IDLE.
REQ-021 Byte 00 or FF in any state SHALL emit nothing, pulse err the next cycle, and return to IDLE.
REQ-022 Emitted event SHALL be written to the FIFO on the rx_valid edge; into an empty FIFO, ev_valid and ev_data SHALL be valid the following cycle (latency 1).
REQ-023 Pop SHALL occur on a cycle with ev_valid & ev_ready; ev_data SHALL update to the next entry the following cycle; ev_ready with an empty FIFO SHALL be ignored.
REQ-024 Push into a full FIFO SHALL be accepted if a pop occurs in the same cycle; otherwise the event is dropped, fifo_cnt is unchanged, and ovf is set.
REQ-025 Simultaneous push and pop on a non-full FIFO SHALL leave fifo_cnt unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 Each accepted make event SHALL increment push_cnt, wrapping FF -> 00; break events and dropped events SHALL NOT increment it.
REQ-027 Each make event SHALL load last_key={ext,code} and set key_down; a break event matching last_key SHALL clear key_down; a non-matching break SHALL leave key_down unchanged.
REQ-028 If clr_ovf and an overflow occur in the same cycle, ovf SHALL end set.

Reset
REQ-029 resetn=0 SHALL immediately force: state=IDLE, FIFO empty (ev_valid=0, fifo_cnt=0), ev_data=0, push_cnt=0, key_down=0, last_key=0, ovf=0, err=0.
REQ-030 A partial prefix sequence in progress when reset is asserted SHALL be discarded.
REQ-031 The first rx_valid after deassertion SHALL be decoded from IDLE.

Configuration
REQ-032 Macro PS2_KEY_CTRL_TYPEMATIC_FILTER_EN: when defined, a make event equal to last_key while key_down=1 (typematic repeat) SHALL be suppressed, with no push, no push_cnt change, and no ovf.
REQ-033 When PS2_KEY_CTRL_TYPEMATIC_FILTER_EN is undefined, every make event SHALL be pushed as in REQ-017..REQ-026.

Verification
REQ-034 Bytes 1C, F0, 1C -> events 01C then 21C; push_cnt=1; key_down 1 then 0; state ends 0.
REQ-035 Bytes E0, 75, E0, F0, 75 -> events 175 then 375; state passes 1, 0, 1, 3, 0.
REQ-036 With ev_ready=0 and DEPTH=8, push 9 makes (15 each) -> fifo_cnt=8, ovf=1, 9th dropped; a push with simultaneous pop when full -> accepted, fifo_cnt stays 8.
REQ-037 Bytes E0, FF, 1C -> err pulse, then event 01C (not 11C).
REQ-038 Bytes 1C, 1C, 1C -> 1 event, push_cnt=1 with filter defined; 3 events, push_cnt=3 without.
REQ-039 resetn pulsed low after E0 with 2 events queued -> all outputs at reset values; the next 1C yields 01C.

Source files
------------

// File: rtl/ps2_key_ctrl_if.sv
// Bus bundle for ps2_key_ctrl: receiver byte strobe in, event stream out,
// plus status. The master side is the receiver/consumer environment and the
// slave side is the controller.
interface ps2_key_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          ev_valid;
  logic          ev_ready;
  logic [9:0]    ev_data;
  logic [CW-1:0] fifo_cnt;
  logic          key_down;
  logic [7:0]    push_cnt;
  logic          ovf;
  logic          clr_ovf;
  logic          err;
  logic [1:0]    state;

  modport master (
    output rx_valid, rx_data, ev_ready, clr_ovf,
    input  ev_valid, ev_data, fifo_cnt, key_down, push_cnt, ovf, err, state
  );

  modport slave (
    input  rx_valid, rx_data, ev_ready, clr_ovf,
    output ev_valid, ev_data, fifo_cnt, key_down, push_cnt, ovf, err, state
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder with event FIFO.
// Folds E0 (extended) and F0 (break) prefixes into a 10-bit event
// {brk, ext, code}, queues events, tracks the last held key and counts makes.
// Optional feature macro: PS2_KEY_CTRL_TYPEMATIC_FILTER_EN drops typematic
// repeats (make of the currently held key) before they reach the FIFO.
module ps2_key_ctrl #(
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           resetn,
  ps2_key_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } st_t;

  st_t           st_q, st_d;
  logic          emit, err_byte;
  logic [9:0]    ev_in;
  logic          make, typ, push_req, pop, full, push_ok, drop;
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [8:0]    last_key_q;
  logic          key_down_q, ovf_q, err_q;
  logic [7:0]    push_cnt_q;

  // Decoder state register; reset drops any half-received prefix.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) st_q <= IDLE;
    else         st_q <= st_d;
  end

  // Decoder next state and event emit; prefixes accumulate as state bits.
  always_comb begin
    st_d     = st_q;
    emit     = 1'b0;
    err_byte = 1'b0;
    if (bus.rx_valid) begin
      if (bus.rx_data == 8'h00 || bus.rx_data == 8'hFF) begin
        err_byte = 1'b1;
        st_d     = IDLE;
      end else if (bus.rx_data == 8'hE0) begin
        st_d = (st_q == BRK || st_q == EXT_BRK) ? EXT_BRK : EXT;
      end else if (bus.rx_data == 8'hF0) begin
        st_d = (st_q == EXT || st_q == EXT_BRK) ? EXT_BRK : BRK;
      end else begin
        emit = 1'b1;
        st_d = IDLE;
      end
    end
  end

  // State encoding doubles as the {brk, ext} event flags.
  assign ev_in = {st_q[1], st_q[0], bus.rx_data};
  assign make  = emit && !st_q[1];

`ifdef PS2_KEY_CTRL_TYPEMATIC_FILTER_EN
  assign typ = make && key_down_q && (ev_in[8:0] == last_key_q);
`else
  assign typ = 1'b0;
`endif

  assign push_req = emit && !typ;
  assign pop      = (cnt_q != '0) && bus.ev_ready;
  assign full     = (cnt_q == CW'(DEPTH));
  // A full FIFO still takes the push when the head leaves this same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Event storage; contents need no reset since reads are gated by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= ev_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!push_ok && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Key tracking, make counter, sticky overflow and error pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_key_q <= '0;
      key_down_q <= 1'b0;
      push_cnt_q <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_byte;
      if (make) begin
        last_key_q <= ev_in[8:0];
        key_down_q <= 1'b1;
      end else if (emit && ev_in[8:0] == last_key_q) begin
        key_down_q <= 1'b0;
      end
      if (push_ok && make) push_cnt_q <= push_cnt_q + 8'd1;
      // Overflow wins over a same-cycle clear so no drop goes unreported.
      if (drop)             ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign bus.ev_valid = (cnt_q != '0);
  assign bus.ev_data  = bus.ev_valid ? mem[rd_ptr] : '0;
  assign bus.fifo_cnt = cnt_q;
  assign bus.key_down = key_down_q;
  assign bus.push_cnt = push_cnt_q;
  assign bus.ovf      = ovf_q;
  assign bus.err      = err_q;
  assign bus.state    = st_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed plus randomized bench for ps2_key_ctrl. The reference model keeps
// prefix flags and an event queue and is updated once per stimulus cycle.
module tb_ps2_key_ctrl;
  localparam int DEPTH = 8;
`ifdef PS2_KEY_CTRL_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int N38  = 1;
`else
  localparam bit FILT = 1'b0;
  localparam int N38  = 3;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ps2_key_ctrl_if #(.DEPTH(DEPTH)) bus();
  ps2_key_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [9:0] mq[$];
  logic       m_brk, m_ext, m_kd, m_ovf, m_err;
  logic [8:0] m_lk;
  logic [7:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_brk = 0; m_ext = 0; m_kd = 0; m_ovf = 0; m_err = 0;
    m_lk = '0; m_pc = '0;
  endtask

  task automatic model_push(input logic [9:0] ev, input bit full, input bit pop, output bit drop);
    drop = 0;
    if (!full || pop) begin
      mq.push_back(ev);
      if (!ev[9]) m_pc = m_pc + 8'd1;
    end else drop = 1;
  endtask

  task automatic model_step(input logic rv, input logic [7:0] b, input logic rdy, input logic clr);
    bit pop, full, drop, emit;
    logic [9:0] ev;
    pop = (mq.size() != 0) && rdy;
    full = (mq.size() == DEPTH);
    drop = 0; emit = 0; ev = '0;
    m_err = rv && (b == 8'h00 || b == 8'hFF);
    if (rv) begin
      if (m_err) begin m_brk = 0; m_ext = 0; end
      else if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin emit = 1; ev = {m_brk, m_ext, b}; m_brk = 0; m_ext = 0; end
    end
    if (pop) void'(mq.pop_front());
    if (emit) begin
      if (!ev[9]) begin
        if (!(FILT && m_kd && m_lk == ev[8:0])) model_push(ev, full, pop, drop);
        m_lk = ev[8:0];
        m_kd = 1;
      end else begin
        model_push(ev, full, pop, drop);
        if (m_lk == ev[8:0]) m_kd = 0;
      end
    end
    m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/ev_valid"}, bus.ev_valid, mq.size() != 0);
    chk({tag, "/ev_data"},  bus.ev_data,  mq.size() != 0 ? mq[0] : 10'h0);
    chk({tag, "/fifo_cnt"}, bus.fifo_cnt, mq.size());
    chk({tag, "/key_down"}, bus.key_down, m_kd);
    chk({tag, "/push_cnt"}, bus.push_cnt, m_pc);
    chk({tag, "/ovf"},      bus.ovf,      m_ovf);
    chk({tag, "/err"},      bus.err,      m_err);
    chk({tag, "/state"},    bus.state,    {m_brk, m_ext});
  endtask

  // Drives one cycle of stimulus, advances the model, checks after the edge.
  task automatic step(input logic rv, input logic [7:0] b, input logic rdy, input logic clr);
    bus.rx_valid = rv; bus.rx_data = b; bus.ev_ready = rdy; bus.clr_ovf = clr;
    model_step(rv, b, rdy, clr);
    @(posedge clk); #1;
    bus.rx_valid = 0; bus.ev_ready = 0; bus.clr_ovf = 0;
    check_all("cyc");
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && mq.size() != 0; i++) step(0, 8'h00, 1, 0);
    chk("drain_empty", bus.fifo_cnt, 0);
  endtask

  initial begin
    logic [7:0] b36, pc0, pick;
    bus.rx_valid = 0; bus.rx_data = 0; bus.ev_ready = 0; bus.clr_ovf = 0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset_ev_data", bus.ev_data, 10'h0);
    resetn = 1;

    // Make then break of the same key.
    step(1, 8'h1C, 0, 0);
    chk("r34_kd1", bus.key_down, 1);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h1C, 0, 0);
    chk("r34_head0", bus.ev_data, 10'h01C);
    chk("r34_cnt", bus.fifo_cnt, 2);
    chk("r34_pc", bus.push_cnt, 1);
    chk("r34_kd0", bus.key_down, 0);
    chk("r34_state", bus.state, 0);
    step(0, 8'h00, 1, 0);
    chk("r34_head1", bus.ev_data, 10'h21C);
    drain();

    // Extended make and extended break with state walk.
    step(1, 8'hE0, 0, 0); chk("r35_s1", bus.state, 1);
    step(1, 8'h75, 0, 0); chk("r35_s0", bus.state, 0);
    step(1, 8'hE0, 0, 0); chk("r35_s1b", bus.state, 1);
    step(1, 8'hF0, 0, 0); chk("r35_s3", bus.state, 3);
    step(1, 8'h75, 0, 0); chk("r35_s0b", bus.state, 0);
    chk("r35_head0", bus.ev_data, 10'h175);
    step(0, 8'h00, 1, 0);
    chk("r35_head1", bus.ev_data, 10'h375);
    drain();

    // Error byte aborts a prefix.
    step(1, 8'hE0, 0, 0);
    step(1, 8'hFF, 0, 0);
    chk("r37_err", bus.err, 1);
    chk("r37_state", bus.state, 0);
    step(1, 8'h1C, 0, 0);
    chk("r37_err_clr", bus.err, 0);
    chk("r37_ev", bus.ev_data, 10'h01C);
    drain();

    // Overflow: nine makes into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      b36 = FILT ? 8'h15 + 8'(i) : 8'h15;
      step(1, b36, 0, 0);
    end
    chk("r36_cnt", bus.fifo_cnt, 8);
    chk("r36_ovf", bus.ovf, 1);
    step(1, 8'h16, 1, 0);
    chk("r36_pushpop_cnt", bus.fifo_cnt, 8);
    step(0, 8'h00, 0, 1);
    chk("r36_clr", bus.ovf, 0);
    step(1, 8'h17, 0, 1);
    chk("r28_ovf_wins", bus.ovf, 1);
    drain();

    // Repeated make of the same key.
    pc0 = m_pc;
    step(1, 8'h1C, 0, 0);
    step(1, 8'h1C, 0, 0);
    step(1, 8'h1C, 0, 0);
    chk("r38_cnt", bus.fifo_cnt, N38);
    chk("r38_pc", bus.push_cnt, 32'(pc0) + N38);
    drain();

    // Reset mid-prefix with events queued.
    step(1, 8'h1C, 0, 0);
    step(1, 8'h2C, 0, 0);
    step(1, 8'hE0, 0, 0);
    resetn = 0; #1;
    model_reset();
    check_all("rst_mid");
    @(posedge clk); #1;
    resetn = 1;
    step(1, 8'h1C, 0, 0);
    chk("r39_ev", bus.ev_data, 10'h01C);
    chk("r39_cnt", bus.fifo_cnt, 1);

    // Randomized traffic with a slow consumer.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 7))
        0: pick = 8'hE0;
        1: pick = 8'hF0;
        2: pick = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF;
        3: pick = 8'h1C;
        4: pick = 8'h75;
        default: pick = 8'($urandom_range(0, 255));
      endcase
      step(1'($urandom_range(0, 1)), pick, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 15) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
